register_bank_write: RTL and testbench



---
 rtl/reg_bank_pkg.sv | 15 +
 rtl/write_operation.sv | 18 +
 rtl/register_bank_write.sv | 116 +++++++++++
 tb/tb_register_bank_write.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/reg_bank_pkg.sv
// Shared constants and state encoding for the 8 x 32-bit register bank.
package reg_bank_pkg;

    localparam int DATA_W    = 32;
    localparam int ADDR_W    = 3;
    localparam int REG_COUNT = 2 ** ADDR_W;

    localparam logic [DATA_W-1:0] RESET_VAL = 32'h0000_0000;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

endpackage

// File: rtl/write_operation.sv
// Combinational address decoder producing a one-hot (or all-zero) write-enable vector.
module write_operation
#(
    parameter int ADDR_W = reg_bank_pkg::ADDR_W
) (
    input  logic [ADDR_W-1:0]      Addr,
    input  logic                   en,
    output logic [2**ADDR_W-1:0]   wEn
);

    always_comb begin
        wEn = '0;
        if (en) begin
            wEn[Addr] = 1'b1;
        end
    end

endmodule

// File: rtl/register_bank_write.sv
// Storage and write side of the register bank: single-word writes plus a
// sequenced eight-cycle bulk clear that walks the bank one register per edge.
module register_bank_write
#(
    parameter int DATA_W = reg_bank_pkg::DATA_W,
    parameter int ADDR_W = reg_bank_pkg::ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we,
    input  logic [ADDR_W-1:0] wAddr,
    input  logic [DATA_W-1:0] wData,
    input  logic              clr_req,
    output logic              busy,
    output logic [DATA_W-1:0] from_reg0,
    output logic [DATA_W-1:0] from_reg1,
    output logic [DATA_W-1:0] from_reg2,
    output logic [DATA_W-1:0] from_reg3,
    output logic [DATA_W-1:0] from_reg4,
    output logic [DATA_W-1:0] from_reg5,
    output logic [DATA_W-1:0] from_reg6,
    output logic [DATA_W-1:0] from_reg7
);

    import reg_bank_pkg::*;

    localparam int NREG = 2 ** ADDR_W;

    state_t            r_state;
    logic [ADDR_W-1:0] r_clr_cnt;
    logic              r_busy;
    logic [DATA_W-1:0] r_regs [NREG];

    logic [ADDR_W-1:0] w_dec_addr;
    logic              w_dec_en;
    logic [NREG-1:0]   w_wen;
    logic [DATA_W-1:0] w_next_data;

    // The shared decoder is steered by the clear counter while clearing,
    // which is also what drops any write that arrives during CLEAR.
    always_comb begin
        w_dec_addr  = wAddr;
        w_dec_en    = we;
        w_next_data = wData;
        if (r_state == CLEAR) begin
            w_dec_addr  = r_clr_cnt;
            w_dec_en    = 1'b1;
            w_next_data = '0;
        end
    end

    write_operation #(
        .ADDR_W (ADDR_W)
    ) u_write_operation (
        .Addr (w_dec_addr),
        .en   (w_dec_en),
        .wEn  (w_wen)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= IDLE;
            r_clr_cnt <= '0;
            r_busy    <= 1'b0;
            for (int unsigned i = 0; i < NREG; i++) begin
                r_regs[i] <= DATA_W'(RESET_VAL);
            end
        end else begin
            for (int unsigned i = 0; i < NREG; i++) begin
                if (w_wen[i]) begin
                    r_regs[i] <= w_next_data;
                end
            end

            case (r_state)
                IDLE: begin
                    if (clr_req) begin
                        r_state   <= CLEAR;
                        r_clr_cnt <= '0;
                        r_busy    <= 1'b1;
                    end
                end
                CLEAR: begin
                    r_clr_cnt <= r_clr_cnt + 1'b1;
                    // A request still held when the last register clears starts the
                    // next pass straight away, so busy shows no gap between passes.
                    if (&r_clr_cnt) begin
                        if (clr_req) begin
                            r_state <= CLEAR;
                            r_busy  <= 1'b1;
                        end else begin
                            r_state <= IDLE;
                            r_busy  <= 1'b0;
                        end
                    end
                end
                default: begin
                    r_state   <= IDLE;
                    r_clr_cnt <= '0;
                    r_busy    <= 1'b0;
                end
            endcase
        end
    end

    assign busy      = r_busy;
    assign from_reg0 = r_regs[0];
    assign from_reg1 = r_regs[1];
    assign from_reg2 = r_regs[2];
    assign from_reg3 = r_regs[3];
    assign from_reg4 = r_regs[4];
    assign from_reg5 = r_regs[5];
    assign from_reg6 = r_regs[6];
    assign from_reg7 = r_regs[7];

endmodule

// File: tb/tb_register_bank_write.sv
// Directed bench for register_bank_write with a per-cycle expected-state scoreboard.
module tb_register_bank_write;

    logic        clk;
    logic        reset;
    logic        we;
    logic [2:0]  wAddr;
    logic [31:0] wData;
    logic        clr_req;
    logic        busy;
    logic [31:0] from_reg0, from_reg1, from_reg2, from_reg3;
    logic [31:0] from_reg4, from_reg5, from_reg6, from_reg7;

    register_bank_write #(
        .DATA_W (32),
        .ADDR_W (3)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .we        (we),
        .wAddr     (wAddr),
        .wData     (wData),
        .clr_req   (clr_req),
        .busy      (busy),
        .from_reg0 (from_reg0),
        .from_reg1 (from_reg1),
        .from_reg2 (from_reg2),
        .from_reg3 (from_reg3),
        .from_reg4 (from_reg4),
        .from_reg5 (from_reg5),
        .from_reg6 (from_reg6),
        .from_reg7 (from_reg7)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0][31:0] regs;
        logic             busy;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    int          busy_cycles = 0;

    logic [31:0] d_regs [8];
    assign d_regs[0] = from_reg0;
    assign d_regs[1] = from_reg1;
    assign d_regs[2] = from_reg2;
    assign d_regs[3] = from_reg3;
    assign d_regs[4] = from_reg4;
    assign d_regs[5] = from_reg5;
    assign d_regs[6] = from_reg6;
    assign d_regs[7] = from_reg7;

    // Reference behaviour of the bank, advanced once per edge.
    logic [31:0] m_regs [8];
    logic        m_clear;
    int          m_cnt;
    logic        m_busy;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic rst, input logic w, input logic [2:0] a,
                        input logic [31:0] d, input logic clr);
        exp_t e;
        exp_t got;
        reset   = rst;
        we      = w;
        wAddr   = a;
        wData   = d;
        clr_req = clr;

        if (rst) begin
            for (int i = 0; i < 8; i++) m_regs[i] = 32'h0;
            m_clear = 1'b0;
            m_cnt   = 0;
            m_busy  = 1'b0;
        end else if (!m_clear) begin
            if (w) m_regs[a] = d;
            if (clr) begin
                m_clear = 1'b1;
                m_cnt   = 0;
                m_busy  = 1'b1;
            end
        end else begin
            m_regs[m_cnt] = 32'h0;
            if (m_cnt == 7) begin
                m_cnt   = 0;
                m_clear = clr;
                m_busy  = clr;
            end else begin
                m_cnt = m_cnt + 1;
            end
        end
        for (int i = 0; i < 8; i++) e.regs[i] = m_regs[i];
        e.busy = m_busy;
        sb.push_back(e);

        @(posedge clk);
        #1;
        got = sb.pop_front();
        for (int i = 0; i < 8; i++) check($sformatf("reg%0d", i), d_regs[i], got.regs[i]);
        check("busy", {31'h0, busy}, {31'h0, got.busy});
        if (busy === 1'b1) busy_cycles++;
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 3'd0, 32'h0, 1'b0);
    endtask

    task automatic load_all();
        for (int k = 0; k < 8; k++) begin
            step(1'b0, 1'b1, 3'(k), 32'h1111_1111 * (k + 1), 1'b0);
        end
    endtask

    initial begin
        reset = 1'b1; we = 1'b0; wAddr = '0; wData = '0; clr_req = 1'b0;
        for (int i = 0; i < 8; i++) m_regs[i] = 32'hx;
        m_clear = 1'b0; m_cnt = 0; m_busy = 1'b0;

        // Reset state, then arbitrary writes, then a 2-cycle reset.
        step(1'b1, 1'b0, 3'd0, 32'h0, 1'b0);
        step(1'b0, 1'b1, 3'd2, 32'hA5A5_0001, 1'b0);
        step(1'b0, 1'b1, 3'd6, 32'h5A5A_0002, 1'b0);
        step(1'b1, 1'b1, 3'd1, 32'hFFFF_FFFF, 1'b0);
        step(1'b1, 1'b0, 3'd0, 32'h0, 1'b1);
        idle();

        // Sequential writes followed by a single-cycle clear pulse.
        load_all();
        idle();
        step(1'b0, 1'b0, 3'd0, 32'h0, 1'b1);
        busy_cycles = 1;
        for (int k = 0; k < 8; k++) idle();
        check("clear_busy_cycles", 32'(busy_cycles), 32'd8);
        idle();

        // Write colliding with the clear request, then a write dropped mid-clear.
        load_all();
        step(1'b0, 1'b1, 3'd3, 32'hDEAD_BEEF, 1'b1);
        check("collide_reg3", from_reg3, 32'hDEAD_BEEF);
        idle();
        step(1'b0, 1'b1, 3'd5, 32'hCAFE_F00D, 1'b0);
        for (int k = 0; k < 6; k++) idle();
        check("dropped_reg5", from_reg5, 32'h0);
        check("collide_reg3_end", from_reg3, 32'h0);
        idle();

        // Reset part way through a clear, then a normal write.
        load_all();
        step(1'b0, 1'b0, 3'd0, 32'h0, 1'b1);
        for (int k = 0; k < 4; k++) idle();
        check("midclr_reg4", from_reg4, 32'h5555_5555);
        step(1'b1, 1'b0, 3'd0, 32'h0, 1'b0);
        check("midclr_busy", {31'h0, busy}, 32'h0);
        step(1'b0, 1'b1, 3'd6, 32'h1234_5678, 1'b0);
        check("post_reset_write", from_reg6, 32'h1234_5678);
        idle();

        // Held request: two back-to-back passes with no idle gap.
        load_all();
        busy_cycles = 0;
        for (int k = 0; k < 12; k++) step(1'b0, 1'b0, 3'd0, 32'h0, 1'b1);
        for (int k = 0; k < 8; k++) idle();
        check("held_busy_cycles", 32'(busy_cycles), 32'd16);
        check("held_busy_end", {31'h0, busy}, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
